// File: rtl/eth_arb_pkg.sv
// eth_arb_pkg: arbiter state type and default maximum frame length
package eth_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} arb_state_t;
  localparam int DEFAULT_MAX_FRAME_BEATS = 1518;
endpackage

// File: rtl/eth_tx_frame_arbiter_rr_select.sv
// eth_rr_select: returns the first set request at or after i_ptr, wrapping modulo N
module eth_rr_select
  import eth_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int IDX_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         i_req,
  input  logic [IDX_WIDTH-1:0] i_ptr,
  output logic                 o_found,
  output logic [IDX_WIDTH-1:0] o_index
);
  logic [IDX_WIDTH-1:0] w_j;
  always_comb begin
    o_found = |i_req;
    o_index = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IDX_WIDTH'((int'(i_ptr) + k) % N);
      o_index = i_req[w_j] ? w_j : o_index;
    end
  end
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-granular round-robin AXIS arbiter with max-length truncation and drain
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_FRAME_BEATS = DEFAULT_MAX_FRAME_BEATS,
  parameter int IDX_WIDTH = $clog2(N),
  parameter int CNT_WIDTH = $clog2(MAX_FRAME_BEATS + 1)
) (
  input  logic                    logic_clk,
  input  logic                    logic_rst_n,
  input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [N-1:0]            s_axis_tvalid,
  input  logic [N-1:0]            s_axis_tlast,
  input  logic [N-1:0]            s_axis_tuser,
  output logic [N-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  input  logic [N-1:0]            cfg_req_enable,
  output logic                    grant_valid,
  output logic [IDX_WIDTH-1:0]    grant_index,
  output logic                    frame_truncated
);
  arb_state_t r_state, w_state_nx;
  logic [IDX_WIDTH-1:0] r_grant, r_ptr, w_sel, w_grant_inc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic w_found, w_src_valid, w_src_last, w_src_user, w_at_max, w_accept, w_done;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [KEEP_WIDTH-1:0] w_src_keep;
  eth_rr_select #(.N(N), .IDX_WIDTH(IDX_WIDTH)) u_rr_select (
    .i_req  (s_axis_tvalid & cfg_req_enable),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_index(w_sel)
  );
  assign w_src_valid = s_axis_tvalid[r_grant];
  assign w_src_last  = s_axis_tlast[r_grant];
  assign w_src_user  = s_axis_tuser[r_grant];
  assign w_src_data  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_src_keep  = s_axis_tkeep[r_grant*KEEP_WIDTH +: KEEP_WIDTH];
  assign w_at_max    = r_cnt == CNT_WIDTH'(MAX_FRAME_BEATS - 1);
  assign w_grant_inc = r_grant == IDX_WIDTH'(N - 1) ? '0 : r_grant + 1'b1;
  assign grant_valid = r_state != IDLE;
  assign grant_index = r_grant;
  always_comb begin
    w_state_nx = r_state;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    m_axis_tuser = 1'b0;
    frame_truncated = 1'b0;
    w_accept = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: w_state_nx = w_found ? XFER : IDLE;
      XFER: begin
        m_axis_tvalid = w_src_valid;
        m_axis_tdata = w_src_data;
        m_axis_tkeep = w_src_keep;
        m_axis_tlast = w_src_last | w_at_max;
        m_axis_tuser = w_src_user | (w_at_max & ~w_src_last);
        s_axis_tready[r_grant] = m_axis_tready;
        w_accept = w_src_valid & m_axis_tready;
        frame_truncated = w_accept & w_at_max & ~w_src_last;
        w_done = w_accept & w_src_last;
        w_state_nx = w_done ? IDLE : frame_truncated ? DRAIN : XFER;
      end
      DRAIN: begin
        s_axis_tready[r_grant] = 1'b1;
        w_done = w_src_valid & w_src_last;
        w_state_nx = w_done ? IDLE : DRAIN;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && w_found) begin
        r_grant <= w_sel;
        r_cnt <= '0;
      end
      if (w_accept) r_cnt <= r_cnt + 1'b1;
      if (w_done) r_ptr <= w_grant_inc;
    end
  end
endmodule
